// File: rtl/dma_priority_arbiter.sv
//==============================================================================
// Module      : dma_priority_arbiter
// Description : Four-channel DMA request arbiter with a HRQ/HLDA bus handshake
//               and one-hot DACK grant. Define ROTATING_PRIORITY_EN for rotating
//               priority; fixed priority (channel 0 highest) otherwise.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dma_priority_arbiter #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [3:0] DREQ,
   input  logic [3:0] swReqSet,
   input  logic [3:0] mask,
   input  logic       HLDA,
   input  logic       serviceDone,
   output logic       HRQ,
   output logic [3:0] DACK,
   output logic [1:0] activeChannel,
   output logic       grantValid
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
   logic [3:0] sw_req_q, sw_req_d;
   logic [3:0] sw_clr;
   logic [3:0] dreq_sync;
   logic [3:0] pending;
   logic [1:0] pick;
   logic [1:0] winner_q, winner_d;
   logic       hrq_q, hrq_d;
   logic [3:0] dack_q, dack_d;
   logic       gv_q, gv_d;

   // Stage 0 captures DREQ; the last stage feeds the arbiter.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], DREQ};
   end

   assign dreq_sync = sync_q[SYNC_STAGES-1];

   // A set pulse coinciding with the clear of the same bit keeps the bit set.
   always_comb begin
      sw_req_d = (sw_req_q & ~sw_clr) | swReqSet;
   end

   assign pending = (dreq_sync | sw_req_q) & ~mask;

`ifdef ROTATING_PRIORITY_EN
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] rot_idx;
   logic       found;

   always_comb begin
      pick    = ptr_q;
      rot_idx = ptr_q;
      found   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rot_idx = ptr_q + 2'(i);
         if (!found && pending[rot_idx]) begin
            pick  = rot_idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ptr_q <= 2'd0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      pick = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pending[i]) begin
            pick = 2'(i);
         end
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      hrq_d    = hrq_q;
      dack_d   = dack_q;
      gv_d     = gv_q;
      sw_clr   = 4'b0000;
`ifdef ROTATING_PRIORITY_EN
      ptr_d    = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pending != 4'b0000) begin
               winner_d = pick;
               hrq_d    = 1'b1;
               state_d  = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            if (HLDA) begin
               dack_d  = 4'b0001 << winner_q;
               gv_d    = 1'b1;
               state_d = ST_SERVICE;
            end else if (pending == 4'b0000) begin
               hrq_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            // serviceDone wins over a simultaneous HLDA drop.
            if (serviceDone) begin
               dack_d  = 4'b0000;
               gv_d    = 1'b0;
               hrq_d   = 1'b0;
               sw_clr  = 4'b0001 << winner_q;
`ifdef ROTATING_PRIORITY_EN
               ptr_d   = winner_q + 2'd1;
`endif
               state_d = ST_IDLE;
            end else if (!HLDA) begin
               dack_d  = 4'b0000;
               gv_d    = 1'b0;
               hrq_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            dack_d  = 4'b0000;
            gv_d    = 1'b0;
            hrq_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= ST_IDLE;
         sync_q   <= '0;
         sw_req_q <= 4'b0000;
         winner_q <= 2'd0;
         hrq_q    <= 1'b0;
         dack_q   <= 4'b0000;
         gv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         sw_req_q <= sw_req_d;
         winner_q <= winner_d;
         hrq_q    <= hrq_d;
         dack_q   <= dack_d;
         gv_q     <= gv_d;
      end
   end

   assign HRQ           = hrq_q;
   assign DACK          = dack_q;
   assign grantValid    = gv_q;
   assign activeChannel = winner_q;

endmodule

`default_nettype wire

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, the number of DREQ synchronizer flops (legal 2..3).
REQ-002 The block SHALL have port CLK, input, 1, the single system clock; all flops are rising-edge.
REQ-003 The block SHALL have port RESET_N, input, 1, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port DREQ, input, 4, the per-channel asynchronous data requests, active-high.
REQ-005 The block SHALL have port swReqSet, input, 4, single-cycle pulses that set software request bits.
REQ-006 The block SHALL have port mask, input, 4, per-channel masks; a 1 blocks that channel.
REQ-007 The block SHALL have port HLDA, input, 1, the hold acknowledge from the bus master.
REQ-008 The block SHALL have port serviceDone, input, 1, a single-cycle pulse from timing-and-control marking end of channel service.
REQ-009 The block SHALL have port HRQ, output, 1, the hold request to the bus master.
REQ-010 The block SHALL have port DACK, output, 4, the one-hot data acknowledges, active-high.
REQ-011 The block SHALL have port activeChannel, output, 2, the encoded index of the granted channel.
REQ-012 The block SHALL have port grantValid, output, 1, asserted while DACK is asserted.

Function
REQ-013 DREQ SHALL pass through SYNC_STAGES flops per bit; the effective request is dreqSync[n] | swReq[n].
REQ-014 pending SHALL equal (dreqSync | swReq) & ~mask, evaluated every cycle.
REQ-015 The FSM SHALL have states IDLE, REQUEST and SERVICE, encoded as 2 bits.
REQ-016 In IDLE with pending != 0, the block SHALL latch the winning channel, drive HRQ=1 on the next edge and enter REQUEST.
REQ-017 In REQUEST with HLDA=1, the block SHALL assert DACK[winner]=1 and grantValid=1 on the next edge and enter SERVICE; the first DACK SHALL appear no earlier than 1 cycle after HLDA is sampled high.
REQ-018 In REQUEST with pending == 0 and HLDA=0, the block SHALL drop HRQ and return to IDLE; the winner SHALL NOT change while in REQUEST.
REQ-019 In SERVICE, DACK and HRQ SHALL hold until serviceDone=1 or HLDA=0.
REQ-020 On serviceDone in SERVICE, the next edge SHALL set DACK=0, grantValid=0 and HRQ=0, clear swReq[winner], update priority and enter IDLE.
REQ-021 On HLDA=0 in SERVICE without serviceDone, the block SHALL abort: DACK=0, HRQ=0, IDLE, with no priority update and no swReq clear.
REQ-022 If HLDA falls and serviceDone is asserted in the same cycle, serviceDone SHALL take precedence.
REQ-023 Masking the granted channel during SERVICE SHALL NOT deassert DACK.
REQ-024 DACK SHALL always be one-hot or zero; activeChannel SHALL hold the last winner while in IDLE.
REQ-025 Under fixed priority, channel 0 SHALL be highest and channel 3 lowest.
REQ-026 A swReqSet pulse on the same cycle as a clear of that bit SHALL leave the bit set.
REQ-027 serviceDone outside SERVICE SHALL be ignored.

Reset
REQ-028 While RESET_N=0, the block SHALL hold HRQ=0, DACK=4'b0000, grantValid=0, activeChannel=2'd0, FSM=IDLE, swReq=0, synchronizers=0 and priority pointer=0 (channel 0 highest).
REQ-029 RESET_N asserted mid-SERVICE SHALL drop DACK and HRQ immediately (asynchronously).

Configuration
REQ-030 With ROTATING_PRIORITY_EN defined, the block SHALL use rotating priority: after serviceDone on channel n, channel (n+1) mod 4 becomes highest and n lowest.
REQ-031 Without ROTATING_PRIORITY_EN, the block SHALL use fixed priority per REQ-025, the pointer logic SHALL be absent, and aborts never alter priority in either mode.

Verification
REQ-032 DREQ=4'b0001, mask=0, HLDA raised 2 cycles after HRQ -> HRQ=1 at 3 cycles (SYNC_STAGES=2), DACK=4'b0001 one cycle after HLDA is sampled, activeChannel=0.
REQ-033 DREQ=4'b1010 held, fixed priority -> DACK=4'b0010; after serviceDone, the next grant is 4'b0010 again.
REQ-034 ROTATING_PRIORITY_EN, DREQ=4'b1111 held, serviceDone after each grant -> grant order 0,1,2,3,0.
REQ-035 mask=4'b0100, DREQ=4'b0100 -> HRQ stays 0; clearing the mask -> HRQ=1 one cycle later.
REQ-036 swReqSet=4'b1000 pulse, DREQ=0 -> DACK=4'b1000; after serviceDone, swReq=0 and HRQ=0.
REQ-037 HLDA dropped mid-SERVICE on channel 2, then RESET_N pulsed during a later SERVICE -> abort to IDLE with the pointer unchanged; reset forces DACK=0 asynchronously.
